// File: rtl/hazard_stall_unit_pkg.sv
// Shared pipeline definitions for the decode-stage hazard and EX-stage forwarding blocks.
// Holds register-index constants, FSM encodings and the common source-match helper.
package hazard_stall_unit_pkg;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    // Wide enough for any mult/div latency from 1 to 15.
    localparam int MD_CNT_W = 4;

    typedef enum logic {
        RUN   = 1'b0,
        HOLD1 = 1'b1
    } hzState_t;

    // Forwarding mux selects consumed by the EX-stage forwarding unit.
    typedef enum logic [1:0] {
        FWD_NONE = 2'd0,
        FWD_MEM  = 2'd1,
        FWD_WB   = 2'd2
    } fwdSel_t;

    // True when a producer's destination is a live, nonzero source of the decode instruction.
    function automatic logic srcMatch(
        input logic [REG_W-1:0] r,
        input logic [REG_W-1:0] regS,
        input logic [REG_W-1:0] regT,
        input logic             usesS,
        input logic             usesT
    );
        return (r != REG_ZERO) && ((usesS && (r == regS)) || (usesT && (r == regT)));
    endfunction

endpackage

// File: rtl/hazard_stall_unit_md_busy_counter.sv
// Load/decrement countdown that reports busy while a multi-cycle unit is still working.
// A load always wins over the decrement, so the caller decides when a start is accepted.
module md_busy_counter
    import hazard_stall_unit_pkg::*;
#(
    parameter int LATENCY = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic busy
);

    logic [MD_CNT_W-1:0] count;
    logic [MD_CNT_W-1:0] countNext;

    always_comb begin
        // NOTE: default assignment first so no path leaves countNext unassigned (no latch).
        countNext = count;
        if (load) begin
            countNext = MD_CNT_W'(LATENCY);
        end else if (count != '0) begin
            countNext = count - 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments; reset is asynchronous, active-low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            busy  <= 1'b0;
        end else begin
            count <= countNext;
            busy  <= (countNext != '0);
        end
    end

endmodule

// File: rtl/hazard_stall_unit.sv
// Decode-stage hazard detector: stalls PC and IF/ID, bubbles ID/EX and flushes IF/ID on
// taken branches whenever forwarding cannot satisfy the decode instruction.
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int MD_LATENCY = 4,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_W-1:0]  if_id_RegS,
    input  logic [REG_W-1:0]  if_id_RegT,
    input  logic              if_id_UsesS,
    input  logic              if_id_UsesT,
    input  logic              if_id_Branch,
    input  logic              if_id_MdStart,
    input  logic              if_id_MdRead,
    input  logic              BranchTaken,
    input  logic [REG_W-1:0]  id_ex_RegD,
    input  logic              id_ex_RegWrite,
    input  logic              id_ex_MemRead,
    input  logic [REG_W-1:0]  ex_m_RegD,
    input  logic              ex_m_MemRead,
    output logic              PCWrite,
    output logic              IF_ID_Write,
    output logic              IF_ID_Flush,
    output logic              ID_EX_Bubble,
    output logic              MdBusy,
    output logic [CNT_W-1:0]  StallCount
);

    hzState_t state;

    logic matchEx;
    logic matchMem;
    logic loadUse;
    logic branchEx;
    logic branchMem;
    logic mdHazard;
    logic hazard;
    logic stall;
    logic mdAccept;
    logic mdBusyQ;

    assign matchEx  = srcMatch(id_ex_RegD, if_id_RegS, if_id_RegT, if_id_UsesS, if_id_UsesT);
    assign matchMem = srcMatch(ex_m_RegD,  if_id_RegS, if_id_RegT, if_id_UsesS, if_id_UsesT);

    assign loadUse   = id_ex_MemRead && matchEx;
    assign branchEx  = if_id_Branch && id_ex_RegWrite && !id_ex_MemRead && matchEx;
    assign branchMem = if_id_Branch && ex_m_MemRead && matchMem;
    assign mdHazard  = (if_id_MdRead || if_id_MdStart) && mdBusyQ;
    assign hazard    = loadUse || branchEx || branchMem || mdHazard;

    // HOLD1 ignores the hazard inputs: it is the second bubble of a load feeding a branch.
    assign stall = (state == HOLD1) || hazard;

    // Reset overrides the Mealy outputs immediately, without waiting for a clock edge.
    assign PCWrite      = rst_n && !stall;
    assign IF_ID_Write  = rst_n && !stall;
    assign ID_EX_Bubble = !rst_n || stall;
    assign IF_ID_Flush  = rst_n && BranchTaken && !stall && (state == RUN);
    assign MdBusy       = mdBusyQ;

    assign mdAccept = (state == RUN) && if_id_MdStart && !stall;

    md_busy_counter #(
        .LATENCY (MD_LATENCY)
    ) u_md_busy (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (mdAccept),
        .busy  (mdBusyQ)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            case (state)
                RUN:     state <= (loadUse && if_id_Branch) ? HOLD1 : RUN;
                HOLD1:   state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            StallCount <= '0;
        end else if (ID_EX_Bubble && (StallCount != {CNT_W{1'b1}})) begin
            StallCount <= StallCount + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: each task drives one scenario and checks outputs
// against hand-computed values; a narrow stall counter exposes saturation quickly.
module tb_hazard_stall_unit;

    localparam int CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic [4:0]       if_id_RegS;
    logic [4:0]       if_id_RegT;
    logic             if_id_UsesS;
    logic             if_id_UsesT;
    logic             if_id_Branch;
    logic             if_id_MdStart;
    logic             if_id_MdRead;
    logic             BranchTaken;
    logic [4:0]       id_ex_RegD;
    logic             id_ex_RegWrite;
    logic             id_ex_MemRead;
    logic [4:0]       ex_m_RegD;
    logic             ex_m_MemRead;
    logic             PCWrite;
    logic             IF_ID_Write;
    logic             IF_ID_Flush;
    logic             ID_EX_Bubble;
    logic             MdBusy;
    logic [CNT_W-1:0] StallCount;

    int assertCount = 0;
    int failCount   = 0;

    // Observed control vector: {PCWrite, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, MdBusy}
    logic [4:0] ctl;
    assign ctl = {PCWrite, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, MdBusy};

    localparam logic [4:0] CTL_RUN       = 5'b11000;
    localparam logic [4:0] CTL_STALL     = 5'b00100;
    localparam logic [4:0] CTL_FLUSH     = 5'b11010;
    localparam logic [4:0] CTL_RUN_BUSY  = 5'b11001;
    localparam logic [4:0] CTL_STALL_BSY = 5'b00101;

    hazard_stall_unit #(
        .MD_LATENCY (4),
        .CNT_W      (CNT_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .if_id_RegS     (if_id_RegS),
        .if_id_RegT     (if_id_RegT),
        .if_id_UsesS    (if_id_UsesS),
        .if_id_UsesT    (if_id_UsesT),
        .if_id_Branch   (if_id_Branch),
        .if_id_MdStart  (if_id_MdStart),
        .if_id_MdRead   (if_id_MdRead),
        .BranchTaken    (BranchTaken),
        .id_ex_RegD     (id_ex_RegD),
        .id_ex_RegWrite (id_ex_RegWrite),
        .id_ex_MemRead  (id_ex_MemRead),
        .ex_m_RegD      (ex_m_RegD),
        .ex_m_MemRead   (ex_m_MemRead),
        .PCWrite        (PCWrite),
        .IF_ID_Write    (IF_ID_Write),
        .IF_ID_Flush    (IF_ID_Flush),
        .ID_EX_Bubble   (ID_EX_Bubble),
        .MdBusy         (MdBusy),
        .StallCount     (StallCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic setNop();
        if_id_RegS     = 5'd0;
        if_id_RegT     = 5'd0;
        if_id_UsesS    = 1'b0;
        if_id_UsesT    = 1'b0;
        if_id_Branch   = 1'b0;
        if_id_MdStart  = 1'b0;
        if_id_MdRead   = 1'b0;
        BranchTaken    = 1'b0;
        id_ex_RegD     = 5'd0;
        id_ex_RegWrite = 1'b0;
        id_ex_MemRead  = 1'b0;
        ex_m_RegD      = 5'd0;
        ex_m_MemRead   = 1'b0;
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        setNop();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        setNop();
        id_ex_MemRead = 1'b1;
        id_ex_RegD    = 5'd8;
        if_id_RegS    = 5'd8;
        if_id_UsesS   = 1'b1;
        BranchTaken   = 1'b1;
        rst_n = 1'b0;
        #2;
        assertCount++;
        if (ctl !== CTL_STALL) begin
            failCount++;
            $display("FAIL reset_ctl: got %b expected %b", ctl, CTL_STALL);
        end
        tick();
        tick();
        assertCount++;
        if (StallCount !== 4'd0) begin
            failCount++;
            $display("FAIL reset_count: got %0d expected 0", StallCount);
        end
        rst_n = 1'b1;
        setNop();
        #1;
        assertCount++;
        if (ctl !== CTL_RUN) begin
            failCount++;
            $display("FAIL reset_release_ctl: got %b expected %b", ctl, CTL_RUN);
        end
    endtask

    task automatic test_load_use();
        doReset();
        id_ex_MemRead = 1'b1;
        id_ex_RegD    = 5'd8;
        if_id_RegS    = 5'd8;
        if_id_UsesS   = 1'b1;
        #1;
        assertCount++;
        if (ctl !== CTL_STALL) begin
            failCount++;
            $display("FAIL lu_stall: got %b expected %b", ctl, CTL_STALL);
        end
        tick();
        setNop();
        if_id_RegS  = 5'd8;
        if_id_UsesS = 1'b1;
        #1;
        assertCount++;
        if (ctl !== CTL_RUN) begin
            failCount++;
            $display("FAIL lu_release: got %b expected %b", ctl, CTL_RUN);
        end
        tick();
        assertCount++;
        if (StallCount !== 4'd1) begin
            failCount++;
            $display("FAIL lu_count: got %0d expected 1", StallCount);
        end
    endtask

    task automatic test_zero_unused();
        doReset();
        id_ex_MemRead = 1'b1;
        id_ex_RegD    = 5'd0;
        if_id_RegS    = 5'd0;
        if_id_UsesS   = 1'b1;
        #1;
        assertCount++;
        if (ctl !== CTL_RUN) begin
            failCount++;
            $display("FAIL zero_reg: got %b expected %b", ctl, CTL_RUN);
        end
        id_ex_RegD  = 5'd8;
        if_id_RegS  = 5'd8;
        if_id_UsesS = 1'b0;
        #1;
        assertCount++;
        if (ctl !== CTL_RUN) begin
            failCount++;
            $display("FAIL unused_src: got %b expected %b", ctl, CTL_RUN);
        end
        if_id_RegT  = 5'd8;
        if_id_UsesT = 1'b1;
        #1;
        assertCount++;
        if (ctl !== CTL_STALL) begin
            failCount++;
            $display("FAIL rt_match: got %b expected %b", ctl, CTL_STALL);
        end
        setNop();
        tick();
    endtask

    task automatic test_load_branch();
        doReset();
        id_ex_MemRead = 1'b1;
        id_ex_RegD    = 5'd5;
        if_id_Branch  = 1'b1;
        if_id_RegT    = 5'd5;
        if_id_UsesT   = 1'b1;
        #1;
        assertCount++;
        if (ctl !== CTL_STALL) begin
            failCount++;
            $display("FAIL lb_cycle1: got %b expected %b", ctl, CTL_STALL);
        end
        tick();
        setNop();
        BranchTaken = 1'b1;
        #1;
        assertCount++;
        if (ctl !== CTL_STALL) begin
            failCount++;
            $display("FAIL lb_hold1: got %b expected %b", ctl, CTL_STALL);
        end
        tick();
        setNop();
        #1;
        assertCount++;
        if (ctl !== CTL_RUN) begin
            failCount++;
            $display("FAIL lb_release: got %b expected %b", ctl, CTL_RUN);
        end
        assertCount++;
        if (StallCount !== 4'd2) begin
            failCount++;
            $display("FAIL lb_count: got %0d expected 2", StallCount);
        end
        tick();
    endtask

    task automatic test_branch_alu();
        doReset();
        id_ex_RegWrite = 1'b1;
        id_ex_RegD     = 5'd3;
        if_id_RegS     = 5'd3;
        if_id_UsesS    = 1'b1;
        #1;
        assertCount++;
        if (ctl !== CTL_RUN) begin
            failCount++;
            $display("FAIL alu_nonbranch: got %b expected %b", ctl, CTL_RUN);
        end
        if_id_Branch = 1'b1;
        BranchTaken  = 1'b1;
        #1;
        assertCount++;
        if (ctl !== CTL_STALL) begin
            failCount++;
            $display("FAIL alu_branch_stall: got %b expected %b", ctl, CTL_STALL);
        end
        tick();
        setNop();
        BranchTaken = 1'b1;
        #1;
        assertCount++;
        if (ctl !== CTL_FLUSH) begin
            failCount++;
            $display("FAIL alu_branch_flush: got %b expected %b", ctl, CTL_FLUSH);
        end
        setNop();
        tick();
    endtask

    task automatic test_branch_mem();
        doReset();
        ex_m_MemRead = 1'b1;
        ex_m_RegD    = 5'd7;
        if_id_RegS   = 5'd7;
        if_id_UsesS  = 1'b1;
        #1;
        assertCount++;
        if (ctl !== CTL_RUN) begin
            failCount++;
            $display("FAIL mem_nonbranch: got %b expected %b", ctl, CTL_RUN);
        end
        if_id_Branch = 1'b1;
        #1;
        assertCount++;
        if (ctl !== CTL_STALL) begin
            failCount++;
            $display("FAIL mem_branch_stall: got %b expected %b", ctl, CTL_STALL);
        end
        tick();
        setNop();
        #1;
        assertCount++;
        if (ctl !== CTL_RUN) begin
            failCount++;
            $display("FAIL mem_branch_release: got %b expected %b", ctl, CTL_RUN);
        end
        tick();
    endtask

    task automatic test_mult_div();
        doReset();
        if_id_MdStart = 1'b1;
        #1;
        assertCount++;
        if (ctl !== CTL_RUN) begin
            failCount++;
            $display("FAIL md_accept: got %b expected %b", ctl, CTL_RUN);
        end
        tick();
        setNop();
        if_id_MdRead = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            assertCount++;
            if (ctl !== CTL_STALL_BSY) begin
                failCount++;
                $display("FAIL md_read_stall%0d: got %b expected %b", i, ctl, CTL_STALL_BSY);
            end
            tick();
        end
        #1;
        assertCount++;
        if (ctl !== CTL_RUN) begin
            failCount++;
            $display("FAIL md_read_go: got %b expected %b", ctl, CTL_RUN);
        end
        assertCount++;
        if (StallCount !== 4'd4) begin
            failCount++;
            $display("FAIL md_count: got %0d expected 4", StallCount);
        end
        setNop();
        if_id_MdStart = 1'b1;
        tick();
        #1;
        assertCount++;
        if (ctl !== CTL_STALL_BSY) begin
            failCount++;
            $display("FAIL md_restart_stall: got %b expected %b", ctl, CTL_STALL_BSY);
        end
        tick();
        setNop();
        #1;
        assertCount++;
        if (ctl !== CTL_RUN_BUSY) begin
            failCount++;
            $display("FAIL md_not_requeued: got %b expected %b", ctl, CTL_RUN_BUSY);
        end
        repeat (3) tick();
        assertCount++;
        if (ctl !== CTL_RUN) begin
            failCount++;
            $display("FAIL md_done: got %b expected %b", ctl, CTL_RUN);
        end
    endtask

    task automatic test_saturation();
        doReset();
        id_ex_MemRead = 1'b1;
        id_ex_RegD    = 5'd9;
        if_id_RegS    = 5'd9;
        if_id_UsesS   = 1'b1;
        repeat (20) tick();
        assertCount++;
        if (StallCount !== 4'hF) begin
            failCount++;
            $display("FAIL count_saturate: got %0d expected 15", StallCount);
        end
        setNop();
        tick();
    endtask

    task automatic test_async_reset();
        doReset();
        if_id_MdStart = 1'b1;
        tick();
        setNop();
        id_ex_MemRead = 1'b1;
        id_ex_RegD    = 5'd5;
        if_id_Branch  = 1'b1;
        if_id_RegS    = 5'd5;
        if_id_UsesS   = 1'b1;
        tick();
        setNop();
        #1;
        assertCount++;
        if (ctl !== CTL_STALL_BSY || StallCount !== 4'd1) begin
            failCount++;
            $display("FAIL hold1_before_reset: got %b/%0d expected %b/1", ctl, StallCount, CTL_STALL_BSY);
        end
        #1;
        rst_n = 1'b0;
        #1;
        assertCount++;
        if (ctl !== CTL_STALL || StallCount !== 4'd0) begin
            failCount++;
            $display("FAIL async_reset: got %b/%0d expected %b/0", ctl, StallCount, CTL_STALL);
        end
        tick();
        rst_n = 1'b1;
        #1;
        assertCount++;
        if (ctl !== CTL_RUN || StallCount !== 4'd0) begin
            failCount++;
            $display("FAIL after_reset: got %b/%0d expected %b/0", ctl, StallCount, CTL_RUN);
        end
        tick();
    endtask

    initial begin
        setNop();
        rst_n = 1'b0;
        test_reset();
        test_load_use();
        test_zero_unused();
        test_load_branch();
        test_branch_alu();
        test_branch_mem();
        test_mult_div();
        test_saturation();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
Decode-stage hazard detector and stall controller. It is the producer-side counterpart to the EX-stage forwarding logic. It decides when the consumer in IF/ID cannot be satisfied by forwarding (load-use, branch operands resolved in ID, multi-cycle mult/div results). It then freezes PC and IF/ID, injects ID/EX bubbles, and flushes IF/ID on taken branches. It also owns the mult/div busy countdown and a saturating stall-cycle performance counter.

Parameters:
MD_LATENCY, 4, cycles from an accepted mult/div start until HI/LO are readable (1..15)
CNT_W, 16, width of StallCount

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
if_id_RegS  in  5  rs of the instruction in decode
if_id_RegT  in  5  rt of the instruction in decode
if_id_UsesS  in  1  decode instruction reads rs
if_id_UsesT  in  1  decode instruction reads rt
if_id_Branch  in  1  decode instruction is a branch comparing registers in ID
if_id_MdStart  in  1  decode instruction is mult/div
if_id_MdRead  in  1  decode instruction is mfhi/mflo
BranchTaken  in  1  branch in ID resolved taken this cycle
id_ex_RegD  in  5  destination register in EX
id_ex_RegWrite  in  1  EX instruction writes a register
id_ex_MemRead  in  1  EX instruction is a load
ex_m_RegD  in  5  destination register in MEM
ex_m_MemRead  in  1  MEM instruction is a load
PCWrite  out  1  PC update enable
IF_ID_Write  out  1  IF/ID register enable
IF_ID_Flush  out  1  zero IF/ID on the next edge
ID_EX_Bubble  out  1  load a NOP into ID/EX on the next edge
MdBusy  out  1  mult/div countdown nonzero
StallCount  out  CNT_W  saturating count of hazard stall cycles

Behaviour:
- The port interface uses one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset (rst_n=0): state=RUN, md_cnt=0, StallCount=0. Outputs are forced to PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1, IF_ID_Flush=0, MdBusy=0.
- Source match: mS(r) = if_id_UsesS && r==if_id_RegS. mT(r) = if_id_UsesT && r==if_id_RegT. match(r) = r!=0 && (mS(r)||mT(r)).
- Hazard terms, evaluated combinationally in RUN:
  - lu = id_ex_MemRead && match(id_ex_RegD).
  - br_ex = if_id_Branch && id_ex_RegWrite && !id_ex_MemRead && match(id_ex_RegD).
  - br_mem = if_id_Branch && ex_m_MemRead && match(ex_m_RegD).
  - md_hz = (if_id_MdRead||if_id_MdStart) && md_cnt!=0.
- stall = lu||br_ex||br_mem||md_hz. Outputs are Mealy in RUN:
  - stall=1 gives PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1.
  - stall=0 gives PCWrite=1, IF_ID_Write=1, ID_EX_Bubble=0.
- FSM states RUN, HOLD1:
  - RUN -> HOLD1 when lu && if_id_Branch. A load feeding a branch needs 2 bubbles.
  - HOLD1 stalls unconditionally for one cycle, ignoring all hazard inputs, then returns to RUN.
  - All other stalls remain in RUN and re-evaluate each cycle.
- Flush: IF_ID_Flush = BranchTaken && !stall && state==RUN. Stall takes priority, so the branch is re-resolved after the stall.
- Mult/div counter:
  - md_cnt loads MD_LATENCY when if_id_MdStart is accepted (RUN, !stall).
  - Otherwise md_cnt decrements while nonzero.
  - MdBusy = md_cnt!=0 (registered).
  - A new MdStart while busy stalls; it is not queued.
- StallCount increments when ID_EX_Bubble=1 and rst_n=1, and saturates at all-ones.
- Reset asserted mid-HOLD1 or mid-countdown aborts immediately to the reset values.

Decomposition:
- Shared pipeline package: REG_ZERO (5'd0), the register-index width (5), and the FSM state encoding (RUN/HOLD1).
- The same package will carry the forwarding-select constants, so both hazard blocks share them.
- One natural sub-module, md_busy_counter: load/decrement countdown with a busy flag, reusable for a future divider.

Test Plan:
- Load-use: id_ex_MemRead=1, id_ex_RegD=8, if_id_RegS=8, UsesS=1 -> one cycle PCWrite=0, IF_ID_Write=0, Bubble=1. Next cycle with ID/EX a NOP -> no stall. StallCount=1.
- $zero and unused sources: repeat the load-use case with RegD=0 -> no stall. Repeat with RegD=8 but UsesS=0 -> no stall.
- Load to branch: id_ex_MemRead=1, RegD=5, if_id_Branch=1, RegT=5, UsesT=1 -> stall 2 consecutive cycles (RUN then HOLD1), even though inputs change to a NOP in cycle 2. StallCount=2.
- Branch vs ALU producer: id_ex_RegWrite=1, MemRead=0, RegD=3, branch reads 3, BranchTaken=1 -> 1 stall with Flush=0. Next cycle, with no hazard and BranchTaken=1 -> Flush=1, PCWrite=1.
- Mult/div: MD_LATENCY=4, MdStart accepted -> MdBusy=1 for 4 cycles. An mfhi in decode the following cycle stalls 4 cycles, then proceeds. A second MdStart during busy also stalls.
- Async reset mid-HOLD1: deassert rst_n between clock edges -> outputs go immediately to reset values (Bubble=1, PCWrite=0). After release, state=RUN, StallCount=0, MdBusy=0.
